// File: rtl/rsa_modexp_core.sv
// Constant-time modular exponentiation: result = base^exponent mod modulus.
// Right-to-left square-and-multiply built on two interleaved shift-add modular
// multipliers. Every run takes the same number of cycles regardless of the
// operand values.
module rsa_modexp_core #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exponent,
    input  logic [W-1:0] modulus,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned AW = W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_EXP,
        S_FIN
    } state_t;

    state_t         state,   state_n;
    logic [W-1:0]   b_reg,   b_n;
    logic [W-1:0]   r_reg,   r_n;
    logic [W-1:0]   e_reg,   e_n;
    logic [W-1:0]   n_reg,   n_n;
    logic [AW-1:0]  acc_p,   acc_p_n;
    logic [AW-1:0]  acc_q,   acc_q_n;
    logic [CW-1:0]  bit_cnt, bit_cnt_n;
    logic [CW-1:0]  exp_idx, exp_idx_n;
    logic           busy_n;
    logic           done_n;
    logic [W-1:0]   result_n;
    logic           err_n;

    logic [AW-1:0]  p_step;
    logic [AW-1:0]  q_step;
    logic [W-1:0]   q_addend;

    // One step of interleaved modular multiplication: acc = (2*acc + a_bit*b) mod n.
    // acc < n on entry keeps every intermediate below 2n, so W+2 bits never overflow.
    function automatic logic [AW-1:0] modmul_step(
        input logic [AW-1:0] acc,
        input logic          a_bit,
        input logic [W-1:0]  b,
        input logic [W-1:0]  n
    );
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = AW'(n);
        t  = {acc[AW-2:0], 1'b0};
        if (t >= nn) begin
            t = t - nn;
        end
        if (a_bit) begin
            t = t + AW'(b);
            if (t >= nn) begin
                t = t - nn;
            end
        end
        return t;
    endfunction

    // During REDUCE the Q unit computes b_reg*1 mod n; during EXP it squares b_reg.
    assign q_addend = (state == S_REDUCE) ? W'(1) : b_reg;
    assign p_step   = modmul_step(acc_p, r_reg[bit_cnt], b_reg, n_reg);
    assign q_step   = modmul_step(acc_q, b_reg[bit_cnt], q_addend, n_reg);

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            b_reg   <= '0;
            r_reg   <= '0;
            e_reg   <= '0;
            n_reg   <= '0;
            acc_p   <= '0;
            acc_q   <= '0;
            bit_cnt <= '0;
            exp_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            b_reg   <= b_n;
            r_reg   <= r_n;
            e_reg   <= e_n;
            n_reg   <= n_n;
            acc_p   <= acc_p_n;
            acc_q   <= acc_q_n;
            bit_cnt <= bit_cnt_n;
            exp_idx <= exp_idx_n;
            busy    <= busy_n;
            done    <= done_n;
            result  <= result_n;
            err     <= err_n;
        end
    end

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_n   = state;
        b_n       = b_reg;
        r_n       = r_reg;
        e_n       = e_reg;
        n_n       = n_reg;
        acc_p_n   = acc_p;
        acc_q_n   = acc_q;
        bit_cnt_n = bit_cnt;
        exp_idx_n = exp_idx;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        result_n  = result;
        err_n     = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (modulus == '0) begin
                        err_n    = 1'b1;
                        result_n = '0;
                        done_n   = 1'b1;
                        state_n  = S_FIN;
                    end else begin
                        err_n   = 1'b0;
                        b_n     = base;
                        e_n     = exponent;
                        n_n     = modulus;
                        busy_n  = 1'b1;
                        state_n = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                r_n       = (n_reg == W'(1)) ? '0 : W'(1);
                exp_idx_n = '0;
                bit_cnt_n = CW'(W - 1);
                acc_p_n   = '0;
                acc_q_n   = '0;
                busy_n    = 1'b1;
                state_n   = S_REDUCE;
            end

            S_REDUCE: begin
                busy_n    = 1'b1;
                acc_q_n   = q_step;
                bit_cnt_n = bit_cnt - CW'(1);
                if (bit_cnt == '0) begin
                    b_n       = q_step[W-1:0];
                    acc_q_n   = '0;
                    bit_cnt_n = CW'(W - 1);
                    state_n   = S_EXP;
                end
            end

            S_EXP: begin
                busy_n    = 1'b1;
                acc_p_n   = p_step;
                acc_q_n   = q_step;
                bit_cnt_n = bit_cnt - CW'(1);
                if (bit_cnt == '0) begin
                    b_n       = q_step[W-1:0];
                    r_n       = e_reg[exp_idx] ? p_step[W-1:0] : r_reg;
                    acc_p_n   = '0;
                    acc_q_n   = '0;
                    bit_cnt_n = CW'(W - 1);
                    exp_idx_n = exp_idx + CW'(1);
                    if (exp_idx == CW'(W - 1)) begin
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        result_n = e_reg[exp_idx] ? p_step[W-1:0] : r_reg;
                        state_n  = S_FIN;
                    end
                end
            end

            S_FIN: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Randomised and directed checks of rsa_modexp_core at W=8 and W=32 against a
// square-and-multiply reference model using 64-bit integer arithmetic.
module tb_rsa_modexp_core;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  base8, exp8, mod8;
    logic        busy8, done8, err8;
    logic [7:0]  result8;

    logic        start32;
    logic [31:0] base32, exp32, mod32;
    logic        busy32, done32, err32;
    logic [31:0] result32;

    int n_checks;
    int n_errors;

    rsa_modexp_core #(.W(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .base     (base8),
        .exponent (exp8),
        .modulus  (mod8),
        .busy     (busy8),
        .done     (done8),
        .result   (result8),
        .err      (err8)
    );

    rsa_modexp_core #(.W(32)) dut32 (
        .clk      (clk),
        .rst      (rst),
        .start    (start32),
        .base     (base32),
        .exponent (exp32),
        .modulus  (mod32),
        .busy     (busy32),
        .done     (done32),
        .result   (result32),
        .err      (err32)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: base^e mod n by right-to-left square-and-multiply.
    function automatic longint unsigned model(input longint unsigned b, input longint unsigned e,
                                              input longint unsigned n, input int w);
        longint unsigned r, bb;
        if (n == 0) return 0;
        r  = 1 % n;
        bb = b % n;
        for (int i = 0; i < w; i++) begin
            if (e[i]) r = (r * bb) % n;
            bb = (bb * bb) % n;
        end
        return r;
    endfunction

    // One W=8 run, called at a negedge. Optional ignored start at glitch_cyc,
    // optional reset abort at rst_cyc.
    task automatic op8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n,
                       input int glitch_cyc, input int rst_cyc, input string tag);
        int cyc;
        int bad;
        int lat;
        int extra;
        longint unsigned exp_r;
        exp_r = model(64'(b), 64'(e), 64'(n), 8);
        lat   = (n == 8'd0) ? 1 : 74;
        base8 = b; exp8 = e; mod8 = n; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1;
        bad = 0;
        while (!done8 && cyc < 200) begin
            if (busy8 !== (cyc < lat)) bad++;
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_busy_shape"}, 64'(bad), 64'd0);
                check({tag, "_rst_busy"},   64'(busy8),   64'd0);
                check({tag, "_rst_done"},   64'(done8),   64'd0);
                check({tag, "_rst_result"}, 64'(result8), 64'd0);
                check({tag, "_rst_err"},    64'(err8),    64'd0);
                return;
            end
            if (cyc == glitch_cyc) begin
                start8 = 1'b1; base8 = 8'h0F; exp8 = 8'h03; mod8 = 8'h0B;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        if (busy8 !== 1'b0) bad++;
        check({tag, "_done"},       64'(done8),   64'd1);
        check({tag, "_latency"},    64'(cyc),     64'(lat));
        check({tag, "_result"},     64'(result8), exp_r);
        check({tag, "_err"},        64'(err8),    64'(n == 8'd0));
        check({tag, "_busy_shape"}, 64'(bad),     64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done8),   64'd0);
        if (glitch_cyc > 0) begin
            extra = 0;
            for (int k = 0; k < 100; k++) begin
                if (done8 || busy8) extra++;
                @(negedge clk);
            end
            check({tag, "_no_second_run"}, 64'(extra), 64'd0);
        end
    endtask

    // One W=32 run, called at a negedge.
    task automatic op32(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n,
                        input string tag);
        int cyc;
        int bad;
        longint unsigned exp_r;
        exp_r = model(64'(b), 64'(e), 64'(n), 32);
        base32 = b; exp32 = e; mod32 = n; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        cyc = 1;
        bad = 0;
        while (!done32 && cyc < 1200) begin
            if (busy32 !== 1'b1) bad++;
            @(negedge clk);
            cyc++;
        end
        if (busy32 !== 1'b0) bad++;
        check({tag, "_done"},    64'(done32),   64'd1);
        check({tag, "_latency"}, 64'(cyc),      64'd1058);
        check({tag, "_result"},  64'(result32), exp_r);
        check({tag, "_err"},     64'(err32),    64'd0);
        check({tag, "_busy"},    64'(bad),      64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rb, re, rn;
        logic [31:0] e32, n32;
        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        start8 = 1'b0;  base8 = '0;  exp8 = '0;  mod8 = '0;
        start32 = 1'b0; base32 = '0; exp32 = '0; mod32 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy8",   64'(busy8),    64'd0);
        check("reset_done8",   64'(done8),    64'd0);
        check("reset_result8", 64'(result8),  64'd0);
        check("reset_err8",    64'(err8),     64'd0);
        check("reset_busy32",  64'(busy32),   64'd0);
        check("reset_result32",64'(result32), 64'd0);
        rst = 1'b0;

        op8(8'd5,   8'd5, 8'd14,  -1, -1, "rsa_enc");
        op8(8'd3,   8'd5, 8'd14,  -1, -1, "rsa_dec");
        op8(8'd200, 8'd5, 8'd14,  -1, -1, "base_ge_n");
        op8(8'd88,  8'd7, 8'd187, -1, -1, "b88_e7_n187");
        op8(8'd200, 8'd0, 8'd14,  -1, -1, "exp_zero");
        op8(8'd0,   8'd9, 8'd14,  -1, -1, "base_zero");
        op8(8'd77,  8'd3, 8'd1,   -1, -1, "mod_one");
        op8(8'd254, 8'd255, 8'd255, -1, -1, "mod_max");
        op8(8'd9,   8'd3, 8'd0,   -1, -1, "mod_zero");
        op8(8'd5,   8'd5, 8'd14,  -1, -1, "err_clear");
        op8(8'd88,  8'd7, 8'd187, 30, -1, "start_while_busy");
        op8(8'd5,   8'd5, 8'd14,  -1, 40, "rst_abort");
        op8(8'd5,   8'd5, 8'd14,  -1, -1, "after_rst");

        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            re = 8'($urandom);
            case (i % 4)
                0: rn = 8'd255;
                1: rn = 8'($urandom_range(2, 15));
                default: rn = 8'($urandom_range(1, 255));
            endcase
            op8(rb, re, rn, -1, -1, $sformatf("rand8_%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            e32 = $urandom;
            n32 = $urandom | 32'd1;
            if (n32 == 32'd1) n32 = 32'd3;
            if (i == 0) n32 = 32'hFFFF_FFFF;
            op32(32'hABCC_EF01, e32, n32, $sformatf("rand32_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
